muldiv_sequencer: RTL

//   Multi-cycle sequencer for the MULT/DIV resource that feeds the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer_sign_fix.sv | 31 +++
 rtl/muldiv_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer that feeds HI/LO.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake and operand/result bundle between the control unit and the MULT/DIV sequencer.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_sequencer_sign_fix.sv
// Combinational sign handling: operand magnitudes at capture, conditional negate of the result.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [WIDTH-1:0]   abs_a,
    output logic [WIDTH-1:0]   abs_b,
    input  logic [2*WIDTH-1:0] acc,
    input  logic               op,
    input  logic               neg_hi,
    input  logic               neg_lo,
    output logic [2*WIDTH-1:0] fixed
);

    always_comb begin
        abs_a = a_in[WIDTH-1] ? -a_in : a_in;
        abs_b = b_in[WIDTH-1] ? -b_in : b_in;
        fixed = acc;
        // A product is one 64-bit number; remainder and quotient are negated independently.
        if (op == OP_MULT) begin
            if (neg_lo) fixed = -acc;
        end else begin
            if (neg_hi) fixed[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
            if (neg_lo) fixed[WIDTH-1:0]       = -acc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency signed MULT (shift-add) / DIV (restoring) sequencer writing HI/LO.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    muldiv_sequencer_if.slave    bus
);
    import muldiv_pkg::*;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               op_q, op_d;
    logic               neg_hi_q, neg_hi_d;
    logic               neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] fixed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .a_in   (bus.a_in),
        .b_in   (bus.b_in),
        .abs_a  (abs_a),
        .abs_b  (abs_b),
        .acc    (acc_q),
        .op     (op_q),
        .neg_hi (neg_hi_q),
        .neg_lo (neg_lo_q),
        .fixed  (fixed)
    );

    // MULT: acc = {partial, multiplier}; DIV: acc = {remainder, dividend->quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        div_diff = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_q};
        div_next = div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    neg_lo_d = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                    neg_hi_d = (bus.op == OP_DIV) ? bus.a_in[WIDTH-1]
                                                  : bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                    cnt_d    = '0;
                    if (bus.op == OP_DIV && bus.b_in == '0) begin
                        state_d = ST_DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        acc_d   = {{WIDTH{1'b0}}, (bus.op == OP_DIV) ? abs_a : abs_b};
                        opnd_d  = (bus.op == OP_DIV) ? abs_b : abs_a;
                    end
                end
            end
            ST_RUN: begin
                acc_d = (op_q == OP_DIV) ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = ST_FIX;
                    cnt_d   = '0;
                end
            end
            ST_FIX: begin
                acc_d   = fixed;
                hi_d    = fixed[2*WIDTH-1:WIDTH];
                lo_d    = fixed[WIDTH-1:0];
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    // Working registers are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clock) begin
        acc_q    <= acc_d;
        opnd_q   <= opnd_d;
        op_q     <= op_d;
        neg_hi_q <= neg_hi_d;
        neg_lo_q <= neg_lo_d;
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.div_zero = dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;

endmodule
